// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect controller for the 5-stage RV32I pipeline.
// A redirect that arrives while fetch is busy is latched and replayed once
// fetch frees (JUMP_PEND). All hold/flush/jump outputs are combinational.
// Optional hold watchdog: define PIPE_CTRL_WDOG_EN to build it; otherwise
// hold_timeout_o is tied to 0.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_ex_i,
  input  logic              ex_mem_re_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_rs1_re_i,
  input  logic              id_rs2_re_i,
  input  logic              fetch_busy_i,
  output logic              pc_hold_o,
  output logic              pc_jump_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic              state_o,
  output logic              hold_timeout_o
);

  typedef enum logic {RUN = 1'b0, JUMP_PEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                load_use;

  // Load-use: EX load writes a register that ID is about to read (x0 never hazards)
  always_comb begin
    load_use = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
               ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));
  end

  // Priority decode of hold/flush/redirect plus next-state; rst masks all controls
  always_comb begin
    pc_hold_o      = 1'b0;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = '0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_hold_o   = 1'b0;
    id_ex_flush_o  = 1'b0;
    state_d        = state_q;
    pend_addr_d    = pend_addr_q;
    unique case (state_q)
      RUN: begin
        if (jump_en_i && !fetch_busy_i) begin
          pc_jump_o      = 1'b1;
          pc_jump_addr_o = jump_addr_i;
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
        end else if (jump_en_i) begin
          // Fetch can't take the redirect now: park it and squash younger work
          pc_hold_o     = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          pend_addr_d   = jump_addr_i;
          state_d       = JUMP_PEND;
        end else if (hold_flag_ex_i) begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
        end else if (load_use) begin
          // Keep the dependent instr in ID, inject one bubble into EX
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (fetch_busy_i) begin
          pc_hold_o     = 1'b1;
          if_id_flush_o = 1'b1;
        end
      end
      JUMP_PEND: begin
        // EX only holds bubbles here, so jump/hold requests are ignored
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (fetch_busy_i) begin
          pc_hold_o = 1'b1;
        end else begin
          pc_jump_o      = 1'b1;
          pc_jump_addr_o = pend_addr_q;
          state_d        = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_hold_o      = 1'b0;
      pc_jump_o      = 1'b0;
      pc_jump_addr_o = '0;
      if_id_hold_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_hold_o   = 1'b0;
      id_ex_flush_o  = 1'b0;
    end
  end

  // FSM state and parked redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign state_o = state_q;

`ifdef PIPE_CTRL_WDOG_EN
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_to_q, wd_to_d;

  // Saturating run-length of consecutive PC holds; sticky trip at HOLD_TIMEOUT
  always_comb begin
    wd_cnt_d = '0;
    if (pc_hold_o)
      wd_cnt_d = (wd_cnt_q == CW'(HOLD_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + 1'b1;
    wd_to_d = wd_to_q || (wd_cnt_d == CW'(HOLD_TIMEOUT));
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_to_q  <= wd_to_d;
    end
  end

  assign hold_timeout_o = wd_to_q;
`else
  assign hold_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a per-cycle reference model checked on every negedge,
// plus directed scenarios with literal expectations.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int HT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          jump_en_i;
  logic [AW-1:0] jump_addr_i;
  logic          hold_flag_ex_i, ex_mem_re_i;
  logic [4:0]    ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
  logic          id_rs1_re_i, id_rs2_re_i, fetch_busy_i;
  logic          pc_hold_o, pc_jump_o, if_id_hold_o, if_id_flush_o;
  logic          id_ex_hold_o, id_ex_flush_o, state_o, hold_timeout_o;
  logic [AW-1:0] pc_jump_addr_o;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.ADDR_W(AW), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .ex_mem_re_i(ex_mem_re_i),
    .ex_rd_addr_i(ex_rd_addr_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs1_re_i(id_rs1_re_i),
    .id_rs2_re_i(id_rs2_re_i), .fetch_busy_i(fetch_busy_i),
    .pc_hold_o(pc_hold_o), .pc_jump_o(pc_jump_o),
    .pc_jump_addr_o(pc_jump_addr_o), .if_id_hold_o(if_id_hold_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_hold_o(id_ex_hold_o),
    .id_ex_flush_o(id_ex_flush_o), .state_o(state_o),
    .hold_timeout_o(hold_timeout_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model state: is a redirect parked, where to, hold run length, tripped flag.
  bit          m_pend = 0;
  bit [AW-1:0] m_addr = '0;
  int          m_run  = 0;
  bit          m_tmo  = 0;

  // packed expected controls: {pc_hold, pc_jump, if_hold, if_flush, ex_hold, ex_flush}
  function automatic bit [5:0] model_ctl(output bit [AW-1:0] addr);
    bit lu;
    addr = '0;
    lu = ex_mem_re_i && ex_rd_addr_i != 0 &&
         ((id_rs1_re_i && id_rs1_addr_i == ex_rd_addr_i) ||
          (id_rs2_re_i && id_rs2_addr_i == ex_rd_addr_i));
    if (rst) return 6'b000000;
    if (m_pend) begin
      if (fetch_busy_i) return 6'b100101;
      addr = m_addr;
      return 6'b010101;
    end
    if (jump_en_i && !fetch_busy_i) begin addr = jump_addr_i; return 6'b010101; end
    if (jump_en_i)      return 6'b100101;
    if (hold_flag_ex_i) return 6'b101010;
    if (lu)             return 6'b101001;
    if (fetch_busy_i)   return 6'b100100;
    return 6'b000000;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on every negedge, then advance the model across the next posedge.
  always @(negedge clk) begin
    bit [5:0]    e;
    bit [AW-1:0] ea;
    bit          tmo_exp;
    e = model_ctl(ea);
    chk("m_ctl", {pc_hold_o, pc_jump_o, if_id_hold_o, if_id_flush_o,
                  id_ex_hold_o, id_ex_flush_o}, AW'(e));
    chk("m_addr", pc_jump_addr_o, ea);
    chk("m_state", state_o, AW'(m_pend));
`ifdef PIPE_CTRL_WDOG_EN
    tmo_exp = m_tmo;
`else
    tmo_exp = 1'b0;
`endif
    chk("m_tmo", hold_timeout_o, AW'(tmo_exp));
    if ((if_id_hold_o && if_id_flush_o) || (id_ex_hold_o && id_ex_flush_o) ||
        (pc_hold_o && pc_jump_o))
      chk("invariant", 1, 0);
    // next-state
    if (rst) begin
      m_pend = 0; m_addr = '0; m_run = 0; m_tmo = 0;
    end else begin
      if (e[5]) m_run++; else m_run = 0;
      if (m_run >= HT) m_tmo = 1;
      if (m_pend) begin
        if (!fetch_busy_i) m_pend = 0;
      end else if (jump_en_i && fetch_busy_i) begin
        m_pend = 1; m_addr = jump_addr_i;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step; @(posedge clk); #1; endtask
  task automatic idle;
    jump_en_i = 0; jump_addr_i = '0; hold_flag_ex_i = 0; ex_mem_re_i = 0;
    ex_rd_addr_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; fetch_busy_i = 0;
  endtask

  initial begin
    bit tmo_lit;
    idle();
    rst = 1;
    jump_en_i = 1; jump_addr_i = 32'h44;
    #2;
    chk("rst_jump", pc_jump_o, 0);
    chk("rst_flush", if_id_flush_o, 0);
    step(); step();
    rst = 0; idle();
    #2 chk("reset_state", state_o, 0);

    // plain redirect
    step();
    jump_en_i = 1; jump_addr_i = 32'h100;
    #2;
    chk("redir_jump", pc_jump_o, 1);
    chk("redir_addr", pc_jump_addr_o, 32'h100);
    chk("redir_flush", {if_id_flush_o, id_ex_flush_o}, 2'b11);
    step(); idle();
    #2 chk("redir_state", state_o, 0);

    // load-use on rs2
    step();
    ex_mem_re_i = 1; ex_rd_addr_i = 5; id_rs2_addr_i = 5; id_rs2_re_i = 1;
    #2 chk("lu_ctl", {pc_hold_o, if_id_hold_o, id_ex_flush_o, if_id_flush_o}, 4'b1110);
    step(); idle();
    #2 chk("lu_clear", pc_hold_o, 0);
    ex_mem_re_i = 1; ex_rd_addr_i = 0; id_rs2_addr_i = 0; id_rs2_re_i = 1;
    #2 chk("lu_x0", {pc_hold_o, if_id_hold_o, id_ex_flush_o}, 3'b000);
    // load-use beats fetch busy: IF/ID held, not flushed
    step();
    ex_rd_addr_i = 7; id_rs1_addr_i = 7; id_rs1_re_i = 1; id_rs2_re_i = 0;
    fetch_busy_i = 1;
    #2 chk("lu_busy", {if_id_hold_o, if_id_flush_o, id_ex_flush_o}, 3'b101);
    step(); idle();

    // pending jump
    step();
    jump_en_i = 1; jump_addr_i = 32'h200; fetch_busy_i = 1;
    #2 chk("pend_enter", {pc_hold_o, pc_jump_o, state_o}, 3'b100);
    for (int i = 0; i < 2; i++) begin
      step(); jump_addr_i = 32'h300;
      #2 chk("pend_busy", {state_o, pc_hold_o, pc_jump_o}, 3'b110);
    end
    step(); fetch_busy_i = 0;
    #2;
    chk("pend_fire", pc_jump_o, 1);
    chk("pend_addr", pc_jump_addr_o, 32'h200);
    step(); idle();
    #2 chk("pend_exit", state_o, 0);

    // EX hold 4 cycles
    for (int i = 0; i < 4; i++) begin
      step(); hold_flag_ex_i = 1;
      #2 chk("ex_hold", {pc_hold_o, if_id_hold_o, id_ex_hold_o,
                         if_id_flush_o, id_ex_flush_o}, 5'b11100);
    end
    step(); idle();

    // reset mid-pend
    step();
    jump_en_i = 1; jump_addr_i = 32'h400; fetch_busy_i = 1;
    step(); jump_en_i = 0;
    #2 chk("rp_state", state_o, 1);
    rst = 1;
    step(); rst = 0; fetch_busy_i = 0;
    #2;
    chk("rp_nojump", pc_jump_o, 0);
    chk("rp_state0", state_o, 0);
    step();
    #2 chk("rp_nojump2", pc_jump_o, 0);

    // watchdog: fresh reset, then 6 busy cycles
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_busy_i = 1; step();
      if (i == 2) chk("wd_before", hold_timeout_o, 0);
      if (i == 3) begin
`ifdef PIPE_CTRL_WDOG_EN
        tmo_lit = 1;
`else
        tmo_lit = 0;
`endif
        chk("wd_trip", hold_timeout_o, AW'(tmo_lit));
      end
    end
    idle(); step(); step();
    chk("wd_sticky", hold_timeout_o, AW'(tmo_lit));
    rst = 1; step(); rst = 0;
    #2 chk("wd_clear", hold_timeout_o, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
